// File: rtl/sep_conv_stream.sv
// Separable 2-D convolution engine: streams 1xK/Kx1 filters and an IMGxIMG
// image, then drains (IMG-K+1)^2 saturated results over a valid/ready port.
module sep_conv_stream #(
  parameter int IMG = 8,
  parameter int K   = 5,
  parameter int DW  = 4,
  parameter int OW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 filter_valid,
  input  logic                 image_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_sat
);

  localparam int M   = IMG - K + 1;
  localparam int NP  = IMG * IMG;
  localparam int NR  = M * M;
  localparam int PCW = $clog2(NP + 1);
  localparam int TCW = $clog2(2 * K + 1);
  localparam int PAW = (NP > 1) ? $clog2(NP) : 1;
  localparam int MCW = $clog2(M + 1);
  localparam int OCW = $clog2(NR + 1);
  localparam int PW0 = 3 * DW + 2 * $clog2(K) + 2;
  localparam int PW  = (PW0 > OW + 1) ? PW0 : OW + 1;

  localparam logic signed [PW-1:0] MAXV =
    PW'((longint'(1) << (OW - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] f1_q  [K];
  logic signed [DW-1:0] f2_q  [K];
  logic signed [DW-1:0] img_q [NP];

  logic [TCW-1:0] tap_q;
  logic [PCW-1:0] pix_q;
  logic [MCW-1:0] r_q, c_q;
  logic [OCW-1:0] cnt_q;

  logic signed [PW-1:0] acc, row;
  logic [PAW-1:0]       idx;
  logic signed [OW-1:0] res_clip;
  logic                 res_sat;

  logic tap_beat, pix_beat, last_pix;
  logic xfer, last_out, present;

  // A beat with both valids high is a filter beat.
  assign tap_beat = in_ready && filter_valid;
  assign pix_beat = in_ready && image_valid && !filter_valid;
  assign last_pix = pix_beat && (pix_q == PCW'(NP - 1));
  assign xfer     = out_valid && out_ready;
  assign last_out = xfer && (cnt_q == OCW'(NR - 1));
  assign present  = (state_q == CALC) || (xfer && !last_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (last_pix) state_d = CALC;
      CALC:    state_d = DRAIN;
      DRAIN:   if (last_out) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (state_q == LOAD) in_ready = 1'b1;
  end

  // Full-precision result for the window at (r_q, c_q).
  always_comb begin
    acc = '0;
    row = '0;
    idx = '0;
    for (int j = 0; j < K; j++) begin
      row = '0;
      for (int i = 0; i < K; i++) begin
        idx = PAW'((int'(r_q) + j) * IMG + int'(c_q) + i);
        row = row + PW'(f1_q[i]) * PW'(img_q[idx]);
      end
      acc = acc + PW'(f2_q[j]) * row;
    end
  end

  always_comb begin
    res_sat  = 1'b0;
    res_clip = OW'(acc);
    if (acc > MAXV) begin
      res_clip = OW'(MAXV);
      res_sat  = 1'b1;
    end else if (acc < MINV) begin
      res_clip = OW'(MINV);
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        f1_q[i] <= '0;
        f2_q[i] <= '0;
      end
      for (int p = 0; p < NP; p++) img_q[p] <= '0;
      tap_q     <= '0;
      pix_q     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (tap_beat) begin
        if (tap_q == TCW'(2 * K)) begin
          f1_q[0] <= in_data;
          tap_q   <= TCW'(1);
        end else begin
          for (int i = 0; i < K; i++) begin
            if (tap_q == TCW'(i))     f1_q[i] <= in_data;
            if (tap_q == TCW'(K + i)) f2_q[i] <= in_data;
          end
          tap_q <= tap_q + 1'b1;
        end
      end
      if (pix_beat) begin
        for (int p = 0; p < NP; p++) begin
          if (pix_q == PCW'(p)) img_q[p] <= in_data;
        end
        pix_q <= pix_q + 1'b1;
      end
      // r_q/c_q always point one ahead of the presented result.
      if (present) begin
        out_valid <= 1'b1;
        out_data  <= res_clip;
        out_sat   <= res_sat;
        if (state_q == DRAIN) cnt_q <= cnt_q + 1'b1;
        if (c_q == MCW'(M - 1)) begin
          c_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
      if (last_out) begin
        out_valid <= 1'b0;
        pix_q     <= '0;
        r_q       <= '0;
        c_q       <= '0;
        cnt_q     <= '0;
      end
    end
  end

endmodule
